// File: rtl/regfile_dump_pkg.sv
// Shared CPU constants and the register-file dump state encoding.
package regfile_dump_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Sequential register-file read-out engine: walks FIRST_REG..NUM_REGS-1 through
// one read port, streams {addr, data} over valid/ready and keeps a running sum.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned ADDR_W    = REG_ADDR_W,
  parameter int unsigned DATA_W    = REG_DATA_W,
  parameter int unsigned FIRST_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state;
  logic [ADDR_W-1:0] ptr;
  logic              accept;

  // Read port follows the walk pointer directly so rd_data is ready in LOAD.
  assign rd_addr = ptr;
  assign accept  = out_valid && out_ready;

  // Dump FSM, address pointer, output word, busy/done flags and checksum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= FIRST_ADDR;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= 1'b0;

      // A word handed over at this edge is counted even if abort arrives with it.
      if (state == SEND && accept) begin
        checksum <= checksum + out_data;
      end

      if (abort && state != IDLE) begin
        state     <= IDLE;
        ptr       <= FIRST_ADDR;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              ptr      <= FIRST_ADDR;
              checksum <= '0;
              busy     <= 1'b1;
              state    <= LOAD;
            end
          end
          LOAD: begin
            out_data  <= rd_data;
            out_addr  <= ptr;
            out_valid <= 1'b1;
            state     <= SEND;
          end
          SEND: begin
            if (accept) begin
              out_valid <= 1'b0;
              if (ptr == LAST_ADDR) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                ptr   <= ptr + ADDR_W'(1);
                state <= LOAD;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: register-file model, transaction-level
// reference model and a per-cycle compare, plus a FIRST_REG=31 build.
module tb_regfile_dump;

  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, out_ready;
  logic [4:0]  rd_addr, out_addr;
  logic [31:0] rd_data, out_data, checksum;
  logic        out_valid, busy, done;

  logic        start2, out_ready2;
  logic [4:0]  rd_addr2, out_addr2;
  logic [31:0] rd_data2, out_data2, checksum2;
  logic        out_valid2, busy2, done2;

  logic [31:0] regs [NR];

  // Register file: combinational read ports.
  assign rd_data  = regs[rd_addr];
  assign rd_data2 = regs[rd_addr2];

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(0)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(31)) dut_last (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .rd_addr(rd_addr2), .rd_data(rd_data2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_addr(out_addr2), .out_data(out_data2),
    .busy(busy2), .done(done2), .checksum(checksum2)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a dump is a list of words FIRST..31, each shown for one
  // gap cycle then offered until taken; the sum covers the words taken.
  bit          m_init = 1'b0;
  bit          m_active, m_load, m_done, m_stall, m_zero;
  int          m_acc;
  logic [4:0]  m_idx;
  logic [31:0] m_sum;
  logic [31:0] prev_data;

  // Model advance on each rising edge from the bench-driven inputs.
  always @(posedge clk) begin
    bit nd;
    nd      = 1'b0;
    m_init  = 1'b1;
    m_stall = 1'b0;
    if (!rst) begin
      m_active = 1'b0; m_load = 1'b0; m_done = 1'b0;
      m_idx = 5'd0; m_sum = 32'd0; m_zero = 1'b1; m_acc = 0;
    end else begin
      if (m_active) begin
        if (!m_load && out_ready) begin
          m_sum = m_sum + regs[m_idx];
          m_acc++;
        end
        if (abort) begin
          m_active = 1'b0; m_load = 1'b0; m_idx = 5'd0;
        end else if (m_load) begin
          m_load = 1'b0;
        end else if (out_ready) begin
          if (m_idx == 5'd31) begin
            m_active = 1'b0; nd = 1'b1;
          end else begin
            m_idx = m_idx + 5'd1; m_load = 1'b1;
          end
        end else begin
          m_stall = 1'b1;
        end
      end else if (!m_done && start && !abort) begin
        m_active = 1'b1; m_load = 1'b1; m_idx = 5'd0;
        m_sum = 32'd0; m_acc = 0; m_zero = 1'b0;
      end
      m_done = nd;
    end
  end

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("checksum", checksum, m_sum);
      chk("out_valid", 32'(out_valid), 32'(m_active && !m_load));
      chk("rd_addr", 32'(rd_addr), 32'(m_idx));
      if (m_active && !m_load) begin
        chk("out_addr", 32'(out_addr), 32'(m_idx));
        chk("out_data", out_data, regs[m_idx]);
        if (m_stall) chk("stall_stable", out_data, prev_data);
      end
      if (m_zero) begin
        chk("idle_out_addr", 32'(out_addr), 32'd0);
        chk("idle_out_data", out_data, 32'd0);
      end
      if (done) done_cnt++;
      prev_data = out_data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Runs from a pending start until done is seen; n counts negedges after the start edge.
  task automatic wait_done(input int budget, input bit rnd, output int n);
    n = 0;
    forever begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      if (done) break;
      if (n >= budget) begin
        checks++; errors++;
        $display("FAIL wait_done: no done after %0d cycles", n);
        break;
      end
      #1;
      start = 1'b0;
    end
    #1;
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic wait_acc(input int k);
    int n;
    n = 0;
    while (m_acc < k && n < 500) begin
      cyc(1);
      n++;
    end
    if (m_acc < k) begin
      checks++; errors++;
      $display("FAIL wait_acc: only %0d of %0d words taken", m_acc, k);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NR; i++) regs[i] = 32'h100 + 32'(i);
  endtask

  initial begin
    int n;
    int words2;
    bit got2;

    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start2 = 1'b0; out_ready2 = 1'b1;
    for (int i = 0; i < NR; i++) regs[i] = 32'd0;
    cyc(3);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_checksum", checksum, 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b1;
    cyc(2);

    // Full dump, consumer always ready.
    load_ramp();
    done_cnt = 0;
    start = 1'b1;
    wait_done(200, 1'b0, n);
    chk("full_cycles", 32'(n), 32'd65);
    chk("full_checksum", checksum, 32'h0000_21F0);
    chk("full_words", 32'(m_acc), 32'd32);
    cyc(3);
    chk("full_done_once", 32'(done_cnt), 32'd1);
    chk("full_busy_after", 32'(busy), 32'd0);
    chk("full_checksum_hold", checksum, 32'h0000_21F0);

    // Same dump with a randomly stalling consumer.
    done_cnt = 0;
    start = 1'b1;
    wait_done(2000, 1'b1, n);
    chk("rand_checksum", checksum, 32'h0000_21F0);
    chk("rand_words", 32'(m_acc), 32'd32);
    cyc(2);
    chk("rand_done_once", 32'(done_cnt), 32'd1);

    // Checksum wrap-around.
    for (int i = 0; i < NR; i++) regs[i] = 32'd0;
    regs[5] = 32'hFFFF_FFFF;
    regs[6] = 32'h0000_0002;
    start = 1'b1;
    wait_done(2000, 1'b1, n);
    chk("wrap_checksum", checksum, 32'h0000_0001);
    cyc(2);

    // Abort while word 11 is stalled in SEND.
    load_ramp();
    done_cnt = 0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_acc(11);
    out_ready = 1'b0;
    cyc(2);
    chk("abort_pending_valid", 32'(out_valid), 32'd1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_checksum", checksum, 32'h0000_0B37);
    cyc(2);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    // start together with abort in IDLE stays idle.
    start = 1'b1; abort = 1'b1;
    cyc(1);
    start = 1'b0; abort = 1'b0;
    chk("abort_wins_busy", 32'(busy), 32'd0);
    chk("abort_wins_checksum", checksum, 32'h0000_0B37);
    out_ready = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("restart_checksum", checksum, 32'd0);
    chk("restart_rd_addr", 32'(rd_addr), 32'd0);
    wait_done(200, 1'b0, n);
    chk("restart_full_checksum", checksum, 32'h0000_21F0);
    cyc(2);

    // Reset mid-dump with word 7 pending; a start while busy is ignored.
    done_cnt = 0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_acc(7);
    out_ready = 1'b0;
    cyc(2);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("busy_start_ignored_acc", 32'(m_acc), 32'd7);
    chk("busy_start_ignored_addr", 32'(out_addr), 32'd7);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    chk("midreset_valid", 32'(out_valid), 32'd0);
    chk("midreset_addr", 32'(out_addr), 32'd0);
    chk("midreset_data", out_data, 32'd0);
    chk("midreset_checksum", checksum, 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    cyc(3);
    chk("midreset_no_done", 32'(done_cnt), 32'd0);

    // Single-word build.
    regs[31] = 32'hDEAD_BEEF;
    words2 = 0;
    got2 = 1'b0;
    start2 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid2) begin
        words2++;
        chk("last_addr", 32'(out_addr2), 32'd31);
        chk("last_data", out_data2, 32'hDEAD_BEEF);
      end
      if (done2) begin
        got2 = 1'b1;
        chk("last_checksum", checksum2, 32'hDEAD_BEEF);
        break;
      end
      #1;
      start2 = 1'b0;
    end
    #1;
    start2 = 1'b0;
    if (!got2) begin
      checks++; errors++;
      $display("FAIL last_done: no done from single-word build");
    end
    chk("last_words", 32'(words2), 32'd1);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
